// File: rtl/switch_cfg_pkg.sv
// switch_box_cfg shared types and size helpers.
// Build option: SWITCH_CFG_PARITY_EN adds even parity to the commit check.
package switch_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        APPLY = 2'd2
    } cfg_state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // One selector holds 0 (undriven) or 1..n (source pin + 1).
    function automatic int sel_w(input int n);
        return clog2(n + 1);
    endfunction

    // All selectors plus the trailing parity bit.
    function automatic int chain_len(input int n);
        return n * sel_w(n) + 1;
    endfunction

endpackage

// File: rtl/switch_route_mux.sv
// Per-pin output selector: sel 0 leaves the pin undriven,
// sel k drives it from pin_i[k-1].
module switch_route_mux #(
    parameter int NPINS = 8,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic [NPINS-1:0] pin_i,
    output logic             pin_o,
    output logic             pin_oe
);

    assign pin_oe = |sel_i;

    // Pick the source pin; out-of-range selectors never reach act.
    always_comb begin
        pin_o = 1'b0;
        for (int q = 0; q < NPINS; q++) begin
            if (sel_i == SEL_W'(q + 1)) begin
                pin_o = pin_i[q];
            end
        end
    end

endmodule

// File: rtl/switch_box_cfg.sv
// Double-buffered switch box: serial shadow chain, checked commit, live routing.
// Build option: SWITCH_CFG_PARITY_EN adds even parity to the commit check.
module switch_box_cfg
    import switch_cfg_pkg::*;
#(
    parameter int                     NPINS = 8,
    parameter logic [NPINS*NPINS-1:0] ALLOW = '1
) (
    input  logic             shift_clk,
    input  logic             shift_rst_n,
    input  logic             shift_en,
    input  logic             shift_i,
    output logic             shift_o,
    input  logic             cfg_commit,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    input  logic [NPINS-1:0] pin_i,
    output logic [NPINS-1:0] pin_o,
    output logic [NPINS-1:0] pin_oe
);

    localparam int SEL_W     = sel_w(NPINS);
    localparam int CHAIN_LEN = chain_len(NPINS);
    localparam int CNT_W     = clog2(CHAIN_LEN + 2);
    localparam int ACT_W     = NPINS * SEL_W;

    cfg_state_e             state_q, state_d;
    logic [CHAIN_LEN-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACT_W-1:0]       act_q, act_d;
    logic                   ok_q, ok_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   ok_c;
    logic                   par_ok;
    logic [SEL_W-1:0]       sel_v;

    assign shift_o  = shadow_q[CHAIN_LEN-1];
    assign cfg_busy = (state_q != IDLE);
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

`ifdef SWITCH_CFG_PARITY_EN
    assign par_ok = ~^shadow_q;
`else
    assign par_ok = 1'b1;
`endif

    // Validate the shadow table: full length, legal, allowed, not self-driven.
    always_comb begin
        ok_c  = (cnt_q == CNT_W'(CHAIN_LEN)) && par_ok;
        sel_v = '0;
        for (int p = 0; p < NPINS; p++) begin
            sel_v = shadow_q[1 + p*SEL_W +: SEL_W];
            if (sel_v > SEL_W'(NPINS)) begin
                ok_c = 1'b0;
            end
            if (sel_v == SEL_W'(p + 1)) begin
                ok_c = 1'b0;
            end
            for (int q = 0; q < NPINS; q++) begin
                if (sel_v == SEL_W'(q + 1) && !ALLOW[p*NPINS + q]) begin
                    ok_c = 1'b0;
                end
            end
        end
    end

    // Commit FSM plus shadow/counter/active-table next state.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        ok_d     = ok_q;
        err_d    = err_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (shift_en) begin
                    shadow_d = {shadow_q[CHAIN_LEN-2:0], shift_i};
                    if (cnt_q != CNT_W'(CHAIN_LEN + 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cfg_commit) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                ok_d    = ok_c;
                state_d = APPLY;
            end
            APPLY: begin
                if (ok_q) begin
                    act_d  = shadow_q[CHAIN_LEN-1:1];
                    err_d  = 1'b0;
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any commit in flight.
    always_ff @(posedge shift_clk or negedge shift_rst_n) begin
        if (!shift_rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            act_q    <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    for (genvar p = 0; p < NPINS; p++) begin : g_pin
        switch_route_mux #(
            .NPINS (NPINS),
            .SEL_W (SEL_W)
        ) u_mux (
            .sel_i  (act_q[p*SEL_W +: SEL_W]),
            .pin_i  (pin_i),
            .pin_o  (pin_o[p]),
            .pin_oe (pin_oe[p])
        );
    end

endmodule

// File: tb/tb_switch_box_cfg.sv
// Directed bench for switch_box_cfg (NPINS=8, CHAIN_LEN=33).
// Pin 1 may not be driven from pin 0 in this instance's ALLOW mask.
module tb_switch_box_cfg;

    logic       clk;
    logic       rst_n;
    logic       shift_en;
    logic       shift_i;
    logic       shift_o;
    logic       cfg_commit;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [7:0] pin_i;
    logic [7:0] pin_o;
    logic [7:0] pin_oe;

    int n_chk = 0;
    int n_err = 0;

    switch_box_cfg #(
        .NPINS (8),
        .ALLOW (64'hFFFF_FFFF_FFFF_FEFF)
    ) dut (
        .shift_clk   (clk),
        .shift_rst_n (rst_n),
        .shift_en    (shift_en),
        .shift_i     (shift_i),
        .shift_o     (shift_o),
        .cfg_commit  (cfg_commit),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .pin_i       (pin_i),
        .pin_o       (pin_o),
        .pin_oe      (pin_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] tbl(input logic [31:0] s);
        return {s, ^s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift the low n bits of w, MSB first; optionally toggle pin 3 and
    // confirm the active route 3->2 stays live on every bit.
    task automatic shift_bits(input logic [32:0] w, input int n,
                              input bit live);
        for (int i = n - 1; i >= 0; i--) begin
            shift_en = 1'b1;
            shift_i  = w[i];
            if (live) begin
                pin_i[3] = i[0];
                #1;
                chk("live_route", 32'(pin_o[2]), 32'(i[0]));
            end
            tick();
        end
        shift_en = 1'b0;
        shift_i  = 1'b0;
    endtask

    // Returns in cycle N+3 after the commit edge N.
    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("busy_check", 32'(cfg_busy), 32'd1);
        tick();
        tick();
    endtask

    task automatic expect_err(input string tag, input logic [7:0] oe);
        chk({tag, "_err"}, 32'(cfg_err), 32'd1);
        chk({tag, "_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_oe"}, 32'(pin_oe), 32'(oe));
    endtask

    task automatic expect_ok(input string tag, input logic [7:0] oe);
        chk({tag, "_done"}, 32'(cfg_done), 32'd1);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_oe"}, 32'(pin_oe), 32'(oe));
    endtask

    initial begin
        rst_n      = 1'b0;
        shift_en   = 1'b0;
        shift_i    = 1'b0;
        cfg_commit = 1'b0;
        pin_i      = 8'h00;
        #12;
        chk("rst_oe", 32'(pin_oe), 32'h0);
        chk("rst_po", 32'(pin_o), 32'h0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        chk("rst_so", 32'(shift_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Valid load: pin 2 from pin 3.
        shift_bits(tbl(32'h0000_0400), 33, 1'b0);
        chk("so_valid", 32'(shift_o), 32'd0);
        commit();
        expect_ok("valid", 8'h04);
        chk("valid_busy", 32'(cfg_busy), 32'd0);
        tick();
        chk("done_pulse", 32'(cfg_done), 32'd0);
        pin_i = 8'h08; #1;
        chk("route_a", 32'(pin_o), 32'h04);
        pin_i = 8'h00; #1;
        chk("route_b", 32'(pin_o), 32'h00);
        pin_i = 8'hF7; #1;
        chk("route_c", 32'(pin_o), 32'h00);
        pin_i = 8'hFF; #1;
        chk("route_d", 32'(pin_o), 32'h04);

        // Short chain: old shadow LSB (1) ends up at the MSB.
        shift_bits(tbl(32'h0000_0002), 32, 1'b0);
        chk("so_short", 32'(shift_o), 32'd1);
        commit();
        expect_err("len", 8'h04);

        // Counter was cleared, so a full table now commits and clears err.
        shift_bits(tbl(32'h0000_0002), 33, 1'b0);
        commit();
        expect_ok("recover", 8'h01);
        pin_i = 8'h02; #1;
        chk("route_e", 32'(pin_o), 32'h01);
        pin_i = 8'hFD; #1;
        chk("route_f", 32'(pin_o), 32'h00);

        shift_bits(tbl(32'h0060_0000), 33, 1'b0);
        commit();
        expect_err("self", 8'h01);
        shift_bits(tbl(32'h0000_0009), 33, 1'b0);
        commit();
        expect_err("range", 8'h01);
        shift_bits(tbl(32'h0000_0010), 33, 1'b0);
        commit();
        expect_err("allow", 8'h01);

        // Flipped parity bit.
        shift_bits({32'h0000_0400, 1'b0}, 33, 1'b0);
        commit();
`ifdef SWITCH_CFG_PARITY_EN
        expect_err("parity", 8'h01);
`else
        expect_ok("parity", 8'h04);
`endif
        shift_bits(tbl(32'h0000_0400), 33, 1'b0);
        commit();
        expect_ok("restore", 8'h04);

        // Live shift of a new table; route 3->2 must keep working.
        shift_bits(tbl(32'h1000_0000), 33, 1'b1);
        shift_en   = 1'b1;
        cfg_commit = 1'b1;
        tick();
        shift_en   = 1'b0;
        cfg_commit = 1'b0;
        chk("commit_shift_busy", 32'(cfg_busy), 32'd0);
        chk("commit_shift_oe", 32'(pin_oe), 32'h04);
        // 34 bits now counted: this commit must fail.
        commit();
        expect_err("overlen", 8'h04);

        shift_bits(tbl(32'h1000_0000), 33, 1'b0);
        cfg_commit = 1'b1;
        tick();
        chk("hold_busy1", 32'(cfg_busy), 32'd1);
        tick();
        cfg_commit = 1'b0;
        chk("hold_busy2", 32'(cfg_busy), 32'd1);
        tick();
        expect_ok("hold", 8'h80);
        pin_i = 8'h01; #1;
        chk("route_g", 32'(pin_o), 32'h80);
        tick();
        chk("hold_idle", 32'(cfg_busy), 32'd0);
        chk("hold_done0", 32'(cfg_done), 32'd0);

        // Reset during APPLY, with err set beforehand.
        commit();
        chk("pre_rst_err", 32'(cfg_err), 32'd1);
        shift_bits(tbl(32'h0000_0400), 33, 1'b0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick();
        chk("apply_busy", 32'(cfg_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", 32'(pin_oe), 32'h0);
        chk("mid_rst_po", 32'(pin_o), 32'h0);
        chk("mid_rst_busy", 32'(cfg_busy), 32'd0);
        chk("mid_rst_err", 32'(cfg_err), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_oe", 32'(pin_oe), 32'h0);
        chk("post_rst_done", 32'(cfg_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/switch_box_cfg.md
# switch_box_cfg

Parametrised, double-buffered successor to the 8-pin switch box. A serial configuration chain loads a shadow routing table while the active routing stays live. A commit handshake validates the table, then atomically transfers it to the active routing. Instances daisy-chain via `shift_i`/`shift_o` in the fabric configuration ring. Pads are split into `pin_i`/`pin_o`/`pin_oe`, so there is no internal tri-state.

## Interface
- `NPINS`, 8: number of pins; must be ≥ 2.
- `ALLOW`, all ones (`NPINS*NPINS` bits): connectivity mask. Bit `p*NPINS+q` = 1 allows pin p to be driven from pin q.
- `SEL_W`, derived: `clog2(NPINS+1)`. Width of one per-pin selector.
- `CHAIN_LEN`, derived: `NPINS*SEL_W+1`. Shadow chain length in bits.

Ports:
- `shift_clk` in 1: the only clock.
- `shift_rst_n` in 1: asynchronous, active-low reset.
- `shift_en` in 1: shift enable.
- `shift_i` in 1: serial config input.
- `shift_o` out 1: serial config output; equals shadow MSB.
- `cfg_commit` in 1: commit request, sampled in IDLE only.
- `cfg_busy` out 1: high while a commit is in progress.
- `cfg_done` out 1: one-cycle pulse; new routing is active.
- `cfg_err` out 1: sticky commit failure flag.
- `pin_i` in NPINS: pad inputs.
- `pin_o` out NPINS: pad outputs.
- `pin_oe` out NPINS: pad output enables.

## Operation
- Shadow chain layout: `{sel[NPINS-1], …, sel[0], par}`. `par` is at bit 0 and is the last bit shifted in.
- Selector values:
  - `sel[p]=0`: pin p undriven.
  - `sel[p]=k`, for 1..NPINS: pin p driven from pin k-1.
- Shifting: on a clock edge with `shift_en=1` in IDLE, `shadow <= {shadow[CHAIN_LEN-2:0], shift_i}` and the bit counter increments.
  - The counter saturates at CHAIN_LEN+1.
  - `shift_en` is ignored while `cfg_busy=1`; shadow and counter hold.
- Active routing is never affected by shifting. This replaces the old behaviour of disabling all drivers during shift.
- Routing is combinational from the active table:
  - `pin_oe[p] = (act[p]!=0)`.
  - `pin_o[p] = pin_oe[p] ? pin_i[act[p]-1] : 0`.
- FSM states: IDLE, CHECK, APPLY.
- IDLE → CHECK when `cfg_commit=1` and `shift_en=0`.
  - A commit with `shift_en=1` is ignored.
  - A commit in CHECK or APPLY is ignored.
- CHECK registers `ok`. `ok` requires all of:
  - the bit counter equals CHAIN_LEN;
  - every `sel[p]` ≤ NPINS;
  - `sel[p] != p+1` (no self-drive);
  - `ALLOW[p*NPINS+sel[p]-1]=1` for every nonzero `sel[p]`;
  - (SWITCH_CFG_PARITY_EN only) XOR of all CHAIN_LEN shadow bits is 0.
- CHECK → APPLY unconditionally.
- APPLY → IDLE:
  - If ok: `act <= shadow sel fields`, `cfg_err <= 0`, and `cfg_done` pulses in the next cycle.
  - If not ok: `act` is unchanged and `cfg_err <= 1`.
  - In both cases the bit counter clears to 0. The shadow is retained.
- `cfg_busy = (state != IDLE)`.
- Reset, asynchronous:
  - state IDLE; shadow, act and counter all 0;
  - `cfg_err=0`, `cfg_done=0`, `shift_o=0`;
  - all `pin_oe=0`, `pin_o=0`.
- Reset mid-commit aborts the commit with no partial transfer.

## Timing
- Commit latency: `cfg_commit` sampled at edge N → CHECK during N+1 → APPLY during N+2. New routing and the `cfg_done` pulse are visible in cycle N+3.
- Back-to-back commits: the earliest accepted next commit is sampled in cycle N+3.
- `shift_o` is registered; it changes one edge after the shift.
- `pin_i`→`pin_o` is purely combinational, with no clock latency.
- `cfg_err` updates at the same edge as act would. It holds until the next successful commit or reset.

## Configuration
- Macro: `SWITCH_CFG_PARITY_EN`.
- Defined: the even-parity check over the full shadow chain is part of `ok`.
- Undefined: the parity check is omitted. `par` is still shifted and counted in CHAIN_LEN, so the chain length is unchanged and mixed rings interoperate.

## Structure
- Package `switch_cfg_pkg`:
  - FSM state enum (IDLE, CHECK, APPLY);
  - `clog2` function;
  - `SEL_W`/`CHAIN_LEN` derivation functions.
- Sub-module `switch_route_mux`: one per pin, generated. It maps `sel`, `pin_i` to `pin_o`, `pin_oe`.
- The FSM, shadow chain, counter and check logic live in `switch_box_cfg`.

## Test plan
All scenarios use NPINS=8, SEL_W=4, CHAIN_LEN=33.
1. Reset: assert `shift_rst_n=0` mid-APPLY → next cycle all `pin_oe=0`, `cfg_busy=0`, `cfg_err=0`, act=0.
2. Valid load: shift 33 bits with `sel[2]=4`, others 0, correct parity; commit → in cycle N+3 `cfg_done=1` and `pin_oe=8'h04`; then toggle `pin_i[3]` → `pin_o[2]` follows.
3. Length error: shift 32 bits, commit → `cfg_err=1` at N+3, `cfg_done=0`, previous routing retained; the counter then reads 0.
4. Illegal selects:
   - `sel[5]=6` (self-drive) → `cfg_err=1`;
   - `sel[0]=9` → `cfg_err=1`;
   - with `ALLOW` bit for pin 1 driven from pin 0 cleared, `sel[1]=1` → `cfg_err=1`.
5. Live shift and ignored commits: with routing from scenario 2 active, shift a new table → `pin_o[2]` keeps following `pin_i[3]` throughout. `cfg_commit` with `shift_en=1` → no busy. A second commit during CHECK → ignored.
6. Parity, with macro defined: flip `par` → `cfg_err=1`. Without the macro, the same stream → `cfg_done=1`.
